// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write enable, optional
// hardwired-zero R0, same-cycle write-to-read bypass and a per-register
// busy scoreboard used by decode to detect pending writebacks.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_Ra,
    input  logic [ADDR_W-1:0] read_Rb,
    output logic [DATA_W-1:0] data_Ra,
    output logic [DATA_W-1:0] data_Rb,
    output logic              busy_Ra,
    output logic              busy_Rb,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_Rd,
    input  logic [DATA_W-1:0] write_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_Rd,
    output logic              any_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic wr_zero;
    logic iss_zero;
    logic wr_ok;
    logic iss_ok;

    // Writes and issues aimed at a hardwired R0 are dropped.
    always_comb begin
        wr_zero  = ZERO_REG && (write_Rd == '0);
        iss_zero = ZERO_REG && (issue_Rd == '0);
        wr_ok    = write_en && !wr_zero;
        iss_ok   = issue_en && !iss_zero;
    end

    // Storage and scoreboard update; reset clears everything and masks both enables.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem  <= '{default: '0};
            busy <= '0;
        end else begin
            if (wr_ok) begin
                mem[write_Rd] <= write_data;
            end
            if (write_en) begin
                busy[write_Rd] <= 1'b0;
            end
            // Set follows the clear so a same-edge new producer keeps the register busy.
            if (iss_ok) begin
                busy[issue_Rd] <= 1'b1;
            end
        end
    end

    // Read port A: storage, optionally forwarded write data, zero register override.
    always_comb begin
        data_Ra = mem[read_Ra];
        busy_Ra = busy[read_Ra];
        if (BYPASS && write_en && (write_Rd == read_Ra)) begin
            busy_Ra = 1'b0;
            if (wr_ok) begin
                data_Ra = write_data;
            end
        end
        if (ZERO_REG && (read_Ra == '0)) begin
            data_Ra = '0;
            busy_Ra = 1'b0;
        end
    end

    // Read port B: identical to port A.
    always_comb begin
        data_Rb = mem[read_Rb];
        busy_Rb = busy[read_Rb];
        if (BYPASS && write_en && (write_Rd == read_Rb)) begin
            busy_Rb = 1'b0;
            if (wr_ok) begin
                data_Rb = write_data;
            end
        end
        if (ZERO_REG && (read_Rb == '0)) begin
            data_Rb = '0;
            busy_Rb = 1'b0;
        end
    end

    // Scoreboard summary from registered state only.
    always_comb begin
        any_busy = |busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two 32x16 instances (zero-reg+bypass, and neither)
// share one stimulus stream and are checked every cycle against an array
// model; a third 16-bit x 8 instance covers the parameter sweep.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ra, rb, wrd, ird;
    logic        we, ie;
    logic [31:0] wdata;

    logic [31:0] da_a, db_a, da_b, db_b;
    logic        ba_a, bb_a, any_a, ba_b, bb_b, any_b;

    logic [2:0]  c_ra, c_rb, c_wrd, c_ird;
    logic        c_we, c_ie;
    logic [15:0] c_wdata, c_da, c_db;
    logic        c_ba, c_bb, c_any;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    // model state: index 0 = zero-reg+bypass instance, 1 = plain instance
    logic [31:0] mem_m [2][16];
    bit          bsy_m [2][16];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .read_Ra(ra), .read_Rb(rb),
        .data_Ra(da_a), .data_Rb(db_a), .busy_Ra(ba_a), .busy_Rb(bb_a),
        .write_en(we), .write_Rd(wrd), .write_data(wdata),
        .issue_en(ie), .issue_Rd(ird), .any_busy(any_a));

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .read_Ra(ra), .read_Rb(rb),
        .data_Ra(da_b), .data_Rb(db_b), .busy_Ra(ba_b), .busy_Rb(bb_b),
        .write_en(we), .write_Rd(wrd), .write_data(wdata),
        .issue_en(ie), .issue_Rd(ird), .any_busy(any_b));

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .read_Ra(c_ra), .read_Rb(c_rb),
        .data_Ra(c_da), .data_Rb(c_db), .busy_Ra(c_ba), .busy_Rb(c_bb),
        .write_en(c_we), .write_Rd(c_wrd), .write_data(c_wdata),
        .issue_en(c_ie), .issue_Rd(c_ird), .any_busy(c_any));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_data(input int i, input logic [3:0] a);
        bit z = (i == 0);
        bit byp = (i == 0);
        if (z && a == 0) return 32'h0;
        if (byp && we && wrd == a && !(z && wrd == 0)) return wdata;
        return mem_m[i][a];
    endfunction

    function automatic logic m_busy(input int i, input logic [3:0] a);
        bit z = (i == 0);
        bit byp = (i == 0);
        if (z && a == 0) return 1'b0;
        if (byp && we && wrd == a) return 1'b0;
        return bsy_m[i][a];
    endfunction

    function automatic logic m_any(input int i);
        logic r = 1'b0;
        for (int k = 0; k < 16; k++) r = r | bsy_m[i][k];
        return r;
    endfunction

    // model update at each rising edge from the inputs held across it
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                for (int k = 0; k < 16; k++) begin
                    mem_m[i][k] = 32'h0;
                    bsy_m[i][k] = 1'b0;
                end
            end else begin
                if (we && !(i == 0 && wrd == 0)) mem_m[i][wrd] = wdata;
                if (we) bsy_m[i][wrd] = 1'b0;
                if (ie && !(i == 0 && ird == 0)) bsy_m[i][ird] = 1'b1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            check("a.data_Ra", da_a, m_data(0, ra));
            check("a.data_Rb", db_a, m_data(0, rb));
            check("a.busy_Ra", 32'(ba_a), 32'(m_busy(0, ra)));
            check("a.busy_Rb", 32'(bb_a), 32'(m_busy(0, rb)));
            check("a.any_busy", 32'(any_a), 32'(m_any(0)));
            check("b.data_Ra", da_b, m_data(1, ra));
            check("b.data_Rb", db_b, m_data(1, rb));
            check("b.busy_Ra", 32'(ba_b), 32'(m_busy(1, ra)));
            check("b.busy_Rb", 32'(bb_b), 32'(m_busy(1, rb)));
            check("b.any_busy", 32'(any_b), 32'(m_any(1)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        ie = 1'b0;
    endtask

    initial begin
        logic [15:0] pat;
        rst_n = 1'b0;
        idle();
        ra = '0; rb = '0; wrd = '0; ird = '0; wdata = '0;
        c_ra = '0; c_rb = '0; c_wrd = '0; c_ird = '0; c_we = 1'b0; c_ie = 1'b0; c_wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // reset read-back
        for (int r = 0; r < 16; r++) begin
            ra = 4'(r);
            rb = 4'(15 - r);
            #1;
            check("rst.a.data", da_a | db_a, 32'h0);
            check("rst.b.data", da_b | db_b, 32'h0);
            check("rst.busy", 32'({ba_a, bb_a, ba_b, bb_b, any_a, any_b}), 32'h0);
            tick();
        end

        // parameter sweep on the 16-bit x 8 instance
        c_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c_wrd = 3'(i);
            c_wdata = {4'(i), ~4'(i), 4'(i), 4'hA};
            tick();
        end
        c_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_ra = 3'(i);
            c_rb = 3'(7 - i);
            pat = (i == 0) ? 16'h0 : {4'(i), ~4'(i), 4'(i), 4'hA};
            #1;
            check("sweep.data_Ra", 32'(c_da), 32'(pat));
            check("sweep.busy", 32'({c_ba, c_bb, c_any}), 32'h0);
            tick();
        end

        // basic write: bypass vs no bypass, then write_en=0 holds
        we = 1'b1; wrd = 4'd5; wdata = 32'hDEADBEEF; ra = 4'd5; rb = 4'd0;
        #1;
        check("wr5.nobyp.same", da_b, 32'h0);
        check("wr5.byp.same", da_a, 32'hDEADBEEF);
        tick();
        we = 1'b0; wdata = 32'h11111111;
        #1;
        check("wr5.nobyp.after", da_b, 32'hDEADBEEF);
        tick();
        check("wr5.hold", da_b, 32'hDEADBEEF);

        // bypass on both ports, zero register
        we = 1'b1; wrd = 4'd3; wdata = 32'h12345678; ra = 4'd3; rb = 4'd3;
        #1;
        check("byp3.Ra", da_a, 32'h12345678);
        check("byp3.Rb", db_a, 32'h12345678);
        tick();
        wrd = 4'd0; wdata = 32'hFFFFFFFF; ra = 4'd0; rb = 4'd0;
        #1;
        check("r0.same", da_a, 32'h0);
        tick();
        we = 1'b0;
        #1;
        check("r0.after", da_a, 32'h0);
        check("r0.plain", da_b, 32'hFFFFFFFF);

        // scoreboard lifecycle on R7
        ie = 1'b1; ird = 4'd7; ra = 4'd7;
        tick();
        ie = 1'b0;
        #1;
        check("sb7.busy", 32'({ba_a, any_a, ba_b, any_b}), 32'hF);
        we = 1'b1; wrd = 4'd7; wdata = 32'hA5;
        #1;
        check("sb7.byp.busy", 32'(ba_a), 32'h0);
        check("sb7.byp.data", da_a, 32'hA5);
        check("sb7.nobyp.busy", 32'(ba_b), 32'h1);
        tick();
        we = 1'b0;
        #1;
        check("sb7.clear", 32'({ba_a, any_a, ba_b, any_b}), 32'h0);

        // simultaneous issue+write: set wins, storage still written
        ie = 1'b1; ird = 4'd9;
        tick();
        we = 1'b1; wrd = 4'd9; wdata = 32'h55;
        tick();
        idle(); ra = 4'd9;
        #1;
        check("sim9.data", da_a, 32'h55);
        check("sim9.busy", 32'({ba_a, ba_b}), 32'h3);
        ie = 1'b1; ird = 4'd0;
        tick();
        ie = 1'b0; ra = 4'd0;
        #1;
        check("iss0.zero", 32'(ba_a), 32'h0);
        check("iss0.plain", 32'(ba_b), 32'h1);
        check("iss0.any", 32'(any_a), 32'h1);

        // reset mid-operation discards state and masks enables
        we = 1'b1; wrd = 4'd2; wdata = 32'h77; ie = 1'b1; ird = 4'd2;
        tick();
        we = 1'b0; ird = 4'd4;
        tick();
        ie = 1'b0; ra = 4'd2;
        #1;
        check("mid.pre", 32'({ba_a, ba_b}), 32'h3);
        rst_n = 1'b0; we = 1'b1; wrd = 4'd2; wdata = 32'h99; ie = 1'b1; ird = 4'd6;
        tick();
        rst_n = 1'b1; idle(); ra = 4'd2; rb = 4'd6;
        #1;
        check("mid.data", da_a | da_b, 32'h0);
        check("mid.busy", 32'({ba_a, bb_a, any_a, ba_b, bb_b, any_b}), 32'h0);

        // randomized traffic with occasional reset
        repeat (3000) begin
            rst_n = ($urandom_range(0, 99) != 0);
            we = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            wrd = 4'($urandom_range(0, 15));
            ird = 4'($urandom_range(0, 15));
            wdata = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? wrd : 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? wrd : 4'($urandom_range(0, 15));
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        cmp_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
